// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b - bin, one bit per clock LSB first; define SERIAL_SUB_OVF_EN to add the ovf output
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic br_q, br_d, borrow_q, borrow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic x, y, d, br_n, load, last;
`ifdef SERIAL_SUB_OVF_EN
  logic am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;
`endif
  always_comb begin
    x = a_q[0];
    y = b_q[0];
    d = x ^ y ^ br_q;
    br_n = (~x & y) | (~(x ^ y) & br_q);
    load = start && state_q != SHIFT;
    last = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    diff_d = diff_q;
    br_d = br_q;
    borrow_d = borrow_q;
    cnt_d = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    am_d = am_q;
    bm_d = bm_q;
    ovf_d = ovf_q;
`endif
    if (load) begin
      state_d = SHIFT;
      a_d = a;
      b_d = b;
      res_d = '0;
      br_d = bin;
      cnt_d = '0;
`ifdef SERIAL_SUB_OVF_EN
      am_d = a[WIDTH-1];
      bm_d = b[WIDTH-1];
`endif
    end else if (state_q == SHIFT) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      res_d = {d, res_q[WIDTH-1:1]};
      br_d = br_n;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        diff_d = {d, res_q[WIDTH-1:1]};
        borrow_d = br_n;
`ifdef SERIAL_SUB_OVF_EN
        // d is the MSB of the result on the last shift
        ovf_d = (am_q ^ bm_q) & (d ^ am_q);
`endif
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      diff_q <= '0;
      br_q <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q <= '0;
`ifdef SERIAL_SUB_OVF_EN
      am_q <= 1'b0;
      bm_q <= 1'b0;
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      diff_q <= diff_d;
      br_q <= br_d;
      borrow_q <= borrow_d;
      cnt_q <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      am_q <= am_d;
      bm_q <= bm_d;
      ovf_q <= ovf_d;
`endif
    end
  end
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign diff = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf = ovf_q;
`endif
endmodule
